shift_add_mult4: RTL and testbench
==================================

SHIFT_ADD_MULT4 -- requirements
Module: shift_add_mult4

Interface
REQ-001 SHALL have parameter N, default 4: operand width; only N=4 is supported.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request to multiply; sampled on rising clk.
REQ-005 SHALL have port a, input, N: multiplicand; captured when start is accepted.
REQ-006 SHALL have port b, input, N: multiplier; captured when start is accepted.
REQ-007 SHALL have port busy, output, 1: high while the block is in CALC.
REQ-008 SHALL have port done, output, 1: one-cycle pulse that marks the result as valid.
REQ-009 SHALL have port product, output, 2N: unsigned a*b.

Function
REQ-010 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-011 SHALL accept start only in IDLE or DONE; start in CALC SHALL be ignored.
REQ-012 On accept: load M<=a, Q<=b, ACC<=0, cycle counter<=0; next state CALC.
REQ-013 Each CALC cycle: if Q[0]=1, {C,ACC}<=ACC+M through the ripple-carry adder with cin=0; otherwise {C,ACC}<={0,ACC}.
REQ-014 In the same CALC cycle, {C,ACC,Q} SHALL shift right by one bit.
REQ-015 SHALL stay in CALC for exactly N cycles, then move to DONE.
REQ-016 DONE SHALL last one cycle; next state is CALC if start=1, otherwise IDLE.
REQ-017 Timing, with start accepted at edge t:
  - busy=1 for cycles t+1..t+N;
  - done=1 only in cycle t+N+1;
  - product={ACC,Q} is valid from cycle t+N+1.
REQ-018 product SHALL hold its last result through IDLE until the next DONE.
REQ-019 product SHALL NOT update during CALC.
REQ-020 Arithmetic SHALL be unsigned; maximum result 15*15=225 fits in 8 bits, so no overflow is possible.
REQ-021 a and b changing after accept SHALL NOT affect the result in progress.
REQ-022 busy and done SHALL never be high in the same cycle.

Reset
REQ-023 rst_n=0 SHALL immediately drive state=IDLE, busy=0, done=0, product=0, and M, Q, ACC, C and counter to 0.
REQ-024 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the result is discarded.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Structure
REQ-026 SHALL instantiate the team's existing 4-bit ripple-carry adder, rca4bit, as its single adder sub-module, with Cin tied to 0.
REQ-027 Constants N and the state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2 SHALL live in shared package mult_pkg.
REQ-028 The cycle counter SHALL be clog2(N)+1 bits wide.

Verification
REQ-029 a=15, b=15, one start pulse -> busy high for 4 cycles, then done pulse with product=225 (8'hE1).
REQ-030 a=9, b=5 -> product=45 (8'h2D); and a=0, b=13 -> product=0, with done still pulsing after 4 CALC cycles.
REQ-031 start held high continuously with a=3, b=7 -> result 21 in DONE. The next operation starts directly from DONE, with no IDLE cycle. No start is taken while busy.
REQ-032 rst_n pulsed low during the 2nd CALC cycle of 12*11 -> outputs are 0 immediately and no done pulse follows. A new start with a=12, b=11 then gives 132.
REQ-033 Change a and b during CALC of 6*7 -> product=42, unaffected by the change.
REQ-034 Exhaustive sweep over all 256 (a,b) pairs, checked against a reference model -> zero mismatches; latency is exactly N+1 cycles from accept to done.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier.
package mult_pkg;

   localparam int N     = 4;
   localparam int CNT_W = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : mult_pkg

// File: rtl/rca4bit.sv
// 4-bit ripple-carry adder built from a chain of full adders.
module rca4bit (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout
);

   logic [4:0] w_carry;

   assign w_carry[0] = i_cin;

   for (genvar g = 0; g < 4; g++) begin : g_fa
      assign o_sum[g]     = i_a[g] ^ i_b[g] ^ w_carry[g];
      assign w_carry[g+1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_cout = w_carry[4];

endmodule : rca4bit

// File: rtl/shift_add_mult4.sv
// Sequential unsigned 4x4 multiplier: one add-and-shift step per CALC cycle,
// result registered on the last step and held until the next operation ends.
module shift_add_mult4
   import mult_pkg::*;
#(
   parameter int N = mult_pkg::N
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   state_t           r_state;
   state_t           w_state_next;
   logic [N-1:0]     r_m;
   logic [N-1:0]     r_q;
   logic [N-1:0]     r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [2*N-1:0]   r_product;

   logic [N-1:0]     w_addend;
   logic [N-1:0]     w_sum;
   logic             w_cout;
   logic             w_accept;
   logic             w_last;

   // Gating M with Q[0] makes a skipped add equal to ACC+0 with no carry out.
   assign w_addend = r_m & {N{r_q[0]}};

   rca4bit u_adder (
      .i_a    (r_acc),
      .i_b    (w_addend),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   assign w_accept = start && (r_state != CALC);
   assign w_last   = (r_cnt == CNT_W'(N - 1));

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (start)  w_state_next = CALC;
         CALC:    if (w_last) w_state_next = DONE;
         DONE:    w_state_next = start ? CALC : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // The carry shifts straight into ACC's MSB, so the shifted-out C is always 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m       <= '0;
         r_q       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_m   <= a;
         r_q   <= b;
         r_acc <= '0;
         r_cnt <= '0;
      end else if (r_state == CALC) begin
         r_acc <= {w_cout, w_sum[N-1:1]};
         r_q   <= {w_sum[0], r_q[N-1:1]};
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_product <= {w_cout, w_sum, r_q[N-1:1]};
         end
      end
   end

   assign busy    = (r_state == CALC);
   assign done    = (r_state == DONE);
   assign product = r_product;

endmodule : shift_add_mult4

// File: tb/tb_shift_add_mult4.sv
// Directed and exhaustive checks for the shift-and-add multiplier.
module tb_shift_add_mult4;

   localparam int N = 4;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int n_pass  = 0;
   int n_total = 0;

   shift_add_mult4 #(.N(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Full single operation; inputs are scrambled after accept to prove they were captured.
   task automatic op_full(input logic [3:0] ta, input logic [3:0] tb_v,
                          input logic [7:0] exp, input logic [7:0] prev, input string tag);
      start = 1'b1; a = ta; b = tb_v;
      @(negedge clk);
      start = 1'b0; a = ~ta; b = ~tb_v;
      for (int i = 0; i < N; i++) begin
         check({tag, " busy"}, 16'(busy), 16'd1);
         check({tag, " no done"}, 16'(done), 16'd0);
         check({tag, " hold prod"}, 16'(product), 16'(prev));
         @(negedge clk);
      end
      check({tag, " done"}, 16'(done), 16'd1);
      check({tag, " idle busy"}, 16'(busy), 16'd0);
      check({tag, " product"}, 16'(product), 16'(exp));
      @(negedge clk);
      check({tag, " done low"}, 16'(done), 16'd0);
      check({tag, " held"}, 16'(product), 16'(exp));
   endtask

   initial begin
      int lat;
      int done_seen;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      #1;
      check("rst busy", 16'(busy), 16'd0);
      check("rst done", 16'(done), 16'd0);
      check("rst product", 16'(product), 16'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      op_full(4'd15, 4'd15, 8'hE1, 8'h00, "15x15");
      op_full(4'd9,  4'd5,  8'h2D, 8'hE1, "9x5");
      op_full(4'd0,  4'd13, 8'h00, 8'h2D, "0x13");

      // start held high: busy exactly N cycles, DONE, then straight back into CALC
      start = 1'b1; a = 4'd3; b = 4'd7;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check("hold busy", 16'(busy), 16'd1);
         check("hold no done", 16'(done), 16'd0);
         @(negedge clk);
      end
      check("hold done", 16'(done), 16'd1);
      check("hold product", 16'(product), 16'd21);
      @(negedge clk);
      check("hold no idle", 16'(busy), 16'd1);
      start = 1'b0;
      for (int i = 1; i < N; i++) @(negedge clk);
      check("hold 2nd busy end", 16'(busy), 16'd1);
      @(negedge clk);
      check("hold 2nd done", 16'(done), 16'd1);
      check("hold 2nd product", 16'(product), 16'd21);
      @(negedge clk);
      check("hold idle", 16'(busy), 16'd0);

      // reset asserted in the 2nd CALC cycle of 12x11
      start = 1'b1; a = 4'd12; b = 4'd11;
      @(negedge clk);
      start = 1'b0;
      check("abort busy c1", 16'(busy), 16'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort busy", 16'(busy), 16'd0);
      check("abort done", 16'(done), 16'd0);
      check("abort product", 16'(product), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("abort no done", 16'(done_seen), 16'd0);
      op_full(4'd12, 4'd11, 8'd132, 8'd0, "12x11");
      op_full(4'd6,  4'd7,  8'd42,  8'd132, "6x7");

      // exhaustive sweep with latency measurement, chained back-to-back from DONE
      for (int i = 0; i < 256; i++) begin
         logic [3:0] sa;
         logic [3:0] sb;
         logic [7:0] exp;
         sa = 4'(i >> 4);
         sb = 4'(i);
         exp = 8'(sa) * 8'(sb);
         start = 1'b1; a = sa; b = sb;
         lat = 0;
         do begin
            @(negedge clk);
            start = 1'b0; a = ~sa; b = ~sb;
            lat++;
         end while (!done && lat < 12);
         check($sformatf("sweep %0dx%0d latency", sa, sb), 16'(lat), 16'(N + 1));
         check($sformatf("sweep %0dx%0d product", sa, sb), 16'(product), 16'(exp));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Watchdog: a hung run still ends with a reported failure.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule : tb_shift_add_mult4
